vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Sole owner of the single-port synchronous framebuffer RAM (640x480, 24-bit RGB, row-major, address = v*640 + h).
- Shares the RAM between three requesters:
  - the vga_ctrl scanout path, which has fixed latency and highest priority;
  - a CPU request port, with valid/ready handshake and a 4-entry in-order queue;
  - a hardware fill engine that clears the screen to one colour.
- Sits between vga_ctrl and the RAM macro in the SoC VGA subsystem.

Parameters:
- AW, 19, RAM address width.
- DW, 24, pixel width (R[23:16] G[15:8] B[7:0]).
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- QDEPTH, 4, CPU request queue depth (power of two).

Ports:
- clk  in  1  system/pixel clock.
- clrn  in  1  synchronous active-low reset.
- scan_req  in  1  scanout wants pixel (scan_h, scan_v) this cycle.
- scan_h  in  10  scanout column.
- scan_v  in  10  scanout row.
- scan_data  out  DW  pixel returned one cycle after scan_req; held otherwise.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  queue can accept.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_addr  in  AW  linear pixel address.
- cpu_req_wdata  in  DW  write data.
- cpu_rsp_valid  out  1  read response pulse.
- cpu_rsp_rdata  out  DW  read data.
- fill_start  in  1  pulse: begin screen fill.
- fill_color  in  DW  fill colour, sampled on fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when fill completes.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  RAM write.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (clrn=0 at a clk edge) clears all state and aborts any fill mid-operation; RAM contents are untouched.
  - Outputs: scan_data=0, cpu_req_ready=0 during reset then 1, cpu_rsp_valid=0, cpu_rsp_rdata=0, fill_busy=0, fill_done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Queue empty; FSM=IDLE.
- Per-cycle grant is fixed priority: scan > CPU queue head > fill. Exactly one grant or none per cycle.
- RAM interface outputs are combinational from the grant. RAM latency is 1 cycle.
- Scan grant:
  - mem_addr = (scan_v<<9)+(scan_v<<7)+scan_h, computed to AW bits.
  - Next cycle, scan_data is registered from mem_rdata.
  - Scan is never stalled. Latency is exactly 1 cycle.
- CPU queue:
  - Enqueue when cpu_req_valid & cpu_req_ready. cpu_req_ready = !full & !fill_busy.
  - Simultaneous enqueue and dequeue on a full queue is allowed; count is unchanged.
  - Head is dequeued on a CPU grant.
  - Address >= H_RES*V_RES (307200):
    - write: dequeued with no RAM access (mem_en=0 that cycle);
    - read: completes with rdata=0, same timing as a valid read.
  - Read response: cpu_rsp_valid pulses 1 cycle after the grant, with cpu_rsp_rdata = mem_rdata (held until the next response).
  - Responses are strictly in request order.
  - Write-then-read to the same address returns the new data (queue order guarantees this).
- Fill FSM:
  - IDLE: on fill_start, latch fill_color, set ptr=0, go to FILL.
    - fill_start while the queue is non-empty: wait in DRAIN (ready=0) until the queue is empty, then go to FILL.
  - FILL: on each fill grant, write fill_color at ptr and increment ptr. After writing ptr=307199, go to DONE.
  - DONE: pulse fill_done for 1 cycle, clear fill_busy, return to IDLE.
  - fill_busy=1 in DRAIN, FILL and DONE.
  - fill_start while busy is ignored.
  - Fill only progresses in cycles without scan_req, so it completes during blanking and non-requested cycles.
- No timeouts: CPU/fill starvation during continuous scan_req is permitted.

Test Plan:
- Reset: assert clrn=0 for 2 cycles with traffic on all ports -> all outputs 0, queue empty, cpu_req_ready=1 the first cycle after release.
- Scan priority: scan_req with (h=5, v=2) coincident with a CPU read of address 0 -> mem_addr=1285 (0x505); scan_data valid next cycle; CPU read granted the first cycle scan_req=0, with cpu_rsp_valid one cycle after that grant.
- Queue full and order: enqueue 4 writes (addr 10..13, data 0xAA0000+i) under continuous scan_req -> cpu_req_ready=0 after the 4th.
  - Then drop scan_req and issue a read of 12 -> writes commit in order; the read returns 0xAA0002.
- Out of range: write to 307200, then read 307200 -> no mem_we pulse; read returns rsp_valid with rdata=0.
- Fill: fill_start with color 0x00FF00 and scan_req=0 -> fill_busy for 307200 write cycles plus DONE; fill_done pulses once; reads of addresses 0 and 307199 return 0x00FF00.
- Fill interrupted: reset asserted at ptr=1000 -> fill_busy=0 next cycle, no further mem_we, fill_done never pulses.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter (scan > cpu queue > fill); ports scan_*, cpu_req_*/cpu_rsp_*, fill_*, mem_*
module vga_fb_arbiter #(
  parameter int AW = 19,
  parameter int DW = 24,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          scan_req,
  input  logic [9:0]    scan_h,
  input  logic [9:0]    scan_v,
  output logic [DW-1:0] scan_data,
  input  logic          cpu_req_valid,
  output logic          cpu_req_ready,
  input  logic          cpu_req_we,
  input  logic [AW-1:0] cpu_req_addr,
  input  logic [DW-1:0] cpu_req_wdata,
  output logic          cpu_rsp_valid,
  output logic [DW-1:0] cpu_rsp_rdata,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int QW = $clog2(QDEPTH);
  localparam logic [AW-1:0] NPIX = AW'(H_RES * V_RES);
  localparam logic [AW-1:0] LAST = AW'(H_RES * V_RES - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, FILL, DONE} state_t;
  state_t state;
  logic          q_we    [QDEPTH];
  logic [AW-1:0] q_addr  [QDEPTH];
  logic [DW-1:0] q_wdata [QDEPTH];
  logic [QW-1:0] rd_ptr, wr_ptr;
  logic [QW:0]   count;
  logic [AW-1:0] ptr, scan_addr;
  logic [DW-1:0] color, scan_hold, rsp_hold;
  logic          scan_pend, rsp_pend, rsp_oob;
  logic          empty, full, enq, scan_g, cpu_g, fill_g, head_oob;
  assign empty         = count == '0;
  assign full          = count == (QW+1)'(QDEPTH);
  assign fill_busy     = state != IDLE;
  assign fill_done     = state == DONE;
  assign scan_g        = clrn & scan_req;
  assign cpu_g         = clrn & !scan_req & !empty;
  assign fill_g        = clrn & !scan_req & empty & (state == FILL);
  assign cpu_req_ready = clrn & !fill_busy & (!full | cpu_g);
  assign enq           = cpu_req_valid & cpu_req_ready;
  assign head_oob      = q_addr[rd_ptr] >= NPIX;
  assign scan_addr     = AW'(scan_v * H_RES + scan_h);
  assign mem_en        = scan_g | (cpu_g & !head_oob) | fill_g;
  assign mem_we        = (cpu_g & q_we[rd_ptr] & !head_oob) | fill_g;
  assign mem_addr      = scan_g ? scan_addr : cpu_g ? q_addr[rd_ptr] : fill_g ? ptr : '0;
  assign mem_wdata     = cpu_g ? q_wdata[rd_ptr] : fill_g ? color : '0;
  assign scan_data     = scan_pend ? mem_rdata : scan_hold;
  assign cpu_rsp_valid = rsp_pend;
  assign cpu_rsp_rdata = rsp_pend ? (rsp_oob ? '0 : mem_rdata) : rsp_hold;
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ptr       <= '0;
      color     <= '0;
      scan_pend <= 1'b0;
      rsp_pend  <= 1'b0;
      rsp_oob   <= 1'b0;
      scan_hold <= '0;
      rsp_hold  <= '0;
    end else begin
      scan_pend <= scan_g;
      rsp_pend  <= cpu_g & !q_we[rd_ptr];
      rsp_oob   <= head_oob;
      scan_hold <= scan_data;
      rsp_hold  <= cpu_rsp_rdata;
      if (enq) begin
        q_we[wr_ptr]    <= cpu_req_we;
        q_addr[wr_ptr]  <= cpu_req_addr;
        q_wdata[wr_ptr] <= cpu_req_wdata;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (cpu_g) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (QW+1)'(enq) - (QW+1)'(cpu_g);
      case (state)
        IDLE: if (fill_start) begin
          color <= fill_color;
          ptr   <= '0;
          state <= (!empty || enq) ? DRAIN : FILL;
        end
        DRAIN: if (empty) state <= FILL;
        FILL: if (fill_g) begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
